// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Arbitrates the register file's single write port among three requesters
//   (wb > ld/dbg round-robin). A write to the SP register that lands in the
//   same cycle as a stack-unit SP update is parked in a hold register and
//   issued once the SP update stream goes quiet, so the requester's value
//   lands after the SP update and nothing is dropped.
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   {wb,ld,dbg}_valid/addr/data/ready   requester handshakes (ready is comb)
//   sp_valid, sp_data          SP update, never back-pressured
//   rf_we/rf_waddr/rf_wdata    registered write port
//   rf_update_sp/rf_new_sp     registered SP-update port
//   hold_busy                  deferred SP-register write pending
//   defer_err                  sticky: deferral ran DEFER_MAX cycles
module regfile_write_scheduler #(
  parameter int DW        = 8,
  parameter int AW        = 2,
  parameter int SP_ADDR   = 3,
  parameter int DEFER_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          dbg_valid,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_ready,
  input  logic          sp_valid,
  input  logic [DW-1:0] sp_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_update_sp,
  output logic [DW-1:0] rf_new_sp,
  output logic          hold_busy,
  output logic          defer_err
);
  localparam int CW = $clog2(DEFER_MAX + 1);
  localparam logic [AW-1:0] SPA = AW'(SP_ADDR);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  state_t        state, state_d;
  logic          rr_dbg;          // 0: ld preferred, 1: dbg preferred
  logic [DW-1:0] hold_data;
  logic [CW-1:0] defer_cnt;
  req_t          gnt;
  logic          xfer, collide, issue_hold;

  // Grant selection: wb wins outright; ld/dbg share by round-robin.
  always_comb begin
    wb_ready  = 1'b0;
    ld_ready  = 1'b0;
    dbg_ready = 1'b0;
    gnt       = '0;
    if (state == IDLE) begin
      if (wb_valid) begin
        wb_ready = 1'b1;
        gnt      = '{addr: wb_addr, data: wb_data};
      end else if (ld_valid && (!dbg_valid || !rr_dbg)) begin
        ld_ready = 1'b1;
        gnt      = '{addr: ld_addr, data: ld_data};
      end else if (dbg_valid) begin
        dbg_ready = 1'b1;
        gnt       = '{addr: dbg_addr, data: dbg_data};
      end
    end
  end

  assign xfer       = wb_ready | ld_ready | dbg_ready;
  assign collide    = xfer && (gnt.addr == SPA) && sp_valid;
  assign issue_hold = (state == HOLD) && !sp_valid;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (collide)    state_d = HOLD;
      HOLD:    if (issue_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_dbg       <= 1'b0;
      hold_data    <= '0;
      defer_cnt    <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      rf_update_sp <= 1'b0;
      rf_new_sp    <= '0;
      hold_busy    <= 1'b0;
      defer_err    <= 1'b0;
    end else begin
      state     <= state_d;
      hold_busy <= (state_d == HOLD);
      if (ld_ready)  rr_dbg <= 1'b1;
      if (dbg_ready) rr_dbg <= 1'b0;

      rf_update_sp <= sp_valid;
      if (sp_valid) rf_new_sp <= sp_data;

      rf_we <= (xfer && !collide) || issue_hold;
      if (issue_hold) begin
        rf_waddr <= SPA;
        rf_wdata <= hold_data;
      end else if (xfer && !collide) begin
        rf_waddr <= gnt.addr;
        rf_wdata <= gnt.data;
      end

      if (collide) begin
        hold_data <= gnt.data;
        defer_cnt <= CW'(1);
      end else if (state == HOLD && sp_valid) begin
        if (defer_cnt < CW'(DEFER_MAX)) defer_cnt <= defer_cnt + CW'(1);
        // the increment taking the count to DEFER_MAX trips the error
        if (defer_cnt >= CW'(DEFER_MAX - 1)) defer_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wb_valid = 0, ld_valid = 0, dbg_valid = 0, sp_valid = 0;
  logic [1:0] wb_addr = 0, ld_addr = 0, dbg_addr = 0;
  logic [7:0] wb_data = 0, ld_data = 0, dbg_data = 0, sp_data = 0;
  logic       wb_ready, ld_ready, dbg_ready;
  logic       rf_we, rf_update_sp, hold_busy, defer_err;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata, rf_new_sp;
  int         checks = 0, passed = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .sp_valid(sp_valid), .sp_data(sp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_update_sp(rf_update_sp), .rf_new_sp(rf_new_sp),
    .hold_busy(hold_busy), .defer_err(defer_err)
  );

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; ld_valid = 0; dbg_valid = 0; sp_valid = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({wb_ready, ld_ready, dbg_ready, rf_we, rf_waddr, rf_wdata, rf_update_sp,
         rf_new_sp, hold_busy, defer_err} !== '0)
      $display("FAIL reset_outputs: got we=%b waddr=%0d wdata=%h usp=%b nsp=%h hb=%b err=%b, want all 0",
               rf_we, rf_waddr, rf_wdata, rf_update_sp, rf_new_sp, hold_busy, defer_err);
    else passed++;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    step();
    wb_valid = 1; wb_addr = 3; wb_data = 8'h99; sp_valid = 1; sp_data = 8'h42;
    step();
    idle_inputs();
    checks++;
    if (hold_busy !== 1'b1) $display("FAIL rst_hold_entry: hold_busy=%b want 1", hold_busy);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_update_sp, rf_new_sp, hold_busy, defer_err} !== '0)
      $display("FAIL rst_hold_async: we=%b usp=%b nsp=%h hb=%b err=%b want all 0",
               rf_we, rf_update_sp, rf_new_sp, hold_busy, defer_err);
    else passed++;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rf_we !== 1'b0 || hold_busy !== 1'b0)
        $display("FAIL rst_hold_dropped[%0d]: we=%b hb=%b want 0 0", i, rf_we, hold_busy);
      else passed++;
    end
  endtask

  task automatic test_priority_rr();
    logic [1:0] exp_addr [6] = '{0, 0, 0, 1, 2, 1};
    logic [2:0] exp_rdy  [6] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b010};
    wb_valid = 1; wb_addr = 0; wb_data = 8'h10;
    ld_valid = 1; ld_addr = 1; ld_data = 8'h11;
    dbg_valid = 1; dbg_addr = 2; dbg_data = 8'h12;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) wb_valid = 0;
      #1;
      checks++;
      if ({wb_ready, ld_ready, dbg_ready} !== exp_rdy[i])
        $display("FAIL prio_ready[%0d]: got %b want %b", i, {wb_ready, ld_ready, dbg_ready}, exp_rdy[i]);
      else passed++;
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== exp_addr[i])
        $display("FAIL prio_write[%0d]: we=%b waddr=%0d want 1 %0d", i, rf_we, rf_waddr, exp_addr[i]);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_collision_wb();
    wb_valid = 1; wb_addr = 3; wb_data = 8'h55; sp_valid = 1; sp_data = 8'hF0;
    #1;
    checks++;
    if (wb_ready !== 1'b1) $display("FAIL coll_ready: wb_ready=%b want 1", wb_ready);
    else passed++;
    step();
    idle_inputs();
    checks++;
    if (rf_update_sp !== 1 || rf_new_sp !== 8'hF0 || rf_we !== 0 || hold_busy !== 1)
      $display("FAIL coll_n1: usp=%b nsp=%h we=%b hb=%b want 1 f0 0 1",
               rf_update_sp, rf_new_sp, rf_we, hold_busy);
    else passed++;
    step();
    checks++;
    if (rf_we !== 1 || rf_waddr !== 2'd3 || rf_wdata !== 8'h55 || hold_busy !== 0 || rf_update_sp !== 0)
      $display("FAIL coll_n2: we=%b waddr=%0d wdata=%h hb=%b usp=%b want 1 3 55 0 0",
               rf_we, rf_waddr, rf_wdata, hold_busy, rf_update_sp);
    else passed++;
  endtask

  task automatic test_parallel_sp();
    ld_valid = 1; ld_addr = 1; ld_data = 8'hA5; sp_valid = 1; sp_data = 8'hFE;
    #1;
    checks++;
    if (ld_ready !== 1'b1) $display("FAIL par_ready: ld_ready=%b want 1", ld_ready);
    else passed++;
    step();
    idle_inputs();
    checks++;
    if (rf_we !== 1 || rf_waddr !== 2'd1 || rf_wdata !== 8'hA5 || rf_update_sp !== 1 ||
        rf_new_sp !== 8'hFE || hold_busy !== 0)
      $display("FAIL par_write: we=%b waddr=%0d wdata=%h usp=%b nsp=%h hb=%b want 1 1 a5 1 fe 0",
               rf_we, rf_waddr, rf_wdata, rf_update_sp, rf_new_sp, hold_busy);
    else passed++;
  endtask

  task automatic test_defer_err();
    dbg_valid = 1; dbg_addr = 3; dbg_data = 8'h3C; sp_valid = 1; sp_data = 8'h11;
    #1;
    checks++;
    if (dbg_ready !== 1'b1) $display("FAIL defer_accept: dbg_ready=%b want 1", dbg_ready);
    else passed++;
    step();
    dbg_valid = 0;
    wb_valid = 1; wb_addr = 0; wb_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({wb_ready, ld_ready, dbg_ready} !== 3'b000)
        $display("FAIL defer_ready[%0d]: got %b want 000", i, {wb_ready, ld_ready, dbg_ready});
      else passed++;
      step();
      checks++;
      if (rf_we !== 0 || hold_busy !== 1 || defer_err !== (i >= 2))
        $display("FAIL defer_hold[%0d]: we=%b hb=%b err=%b want 0 1 %b", i, rf_we, hold_busy,
                 defer_err, (i >= 2));
      else passed++;
    end
    sp_valid = 0;
    #1;
    checks++;
    if (wb_ready !== 1'b0) $display("FAIL defer_last_ready: wb_ready=%b want 0", wb_ready);
    else passed++;
    step();
    checks++;
    if (rf_we !== 1 || rf_waddr !== 2'd3 || rf_wdata !== 8'h3C || hold_busy !== 0 || defer_err !== 1)
      $display("FAIL defer_issue: we=%b waddr=%0d wdata=%h hb=%b err=%b want 1 3 3c 0 1",
               rf_we, rf_waddr, rf_wdata, hold_busy, defer_err);
    else passed++;
    #1;
    checks++;
    if (wb_ready !== 1'b1) $display("FAIL defer_resume: wb_ready=%b want 1", wb_ready);
    else passed++;
    step();
    idle_inputs();
    checks++;
    if (rf_we !== 1 || rf_waddr !== 2'd0 || rf_wdata !== 8'h77 || defer_err !== 1)
      $display("FAIL defer_after: we=%b waddr=%0d wdata=%h err=%b want 1 0 77 1",
               rf_we, rf_waddr, rf_wdata, defer_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_hold();
    test_priority_rr();
    test_collision_wb();
    test_parallel_sp();
    test_defer_err();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
